// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch sequencer: state encodings,
// default configuration values and a small address helper.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_HALT  = 3'd5
  } state_e;

  localparam logic [31:0] DEFAULT_RESET_PC       = 32'h0000_0000;
  localparam int unsigned DEFAULT_PC_STEP        = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

  // Instructions are word aligned; the two low address bits are forced to zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_ctrl_flipflops_32.sv
// fetch_ctrl_flipflops_32
// 32-bit enabled register with synchronous active-high reset. Holds the
// captured instruction word for decode.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous reset, clears q to 0
//   en   in   load enable
//   d    in   data in
//   q    out  registered data
module fetch_ctrl_flipflops_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // Load on enable, clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 32'h0000_0000;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Instruction-fetch sequencer in front of the external 32-bit PC register.
// It drives the PC register D/en, reads its Q back as the current PC, runs a
// req/ack handshake with instruction memory, presents the fetched word to
// decode with valid/ready, and applies redirects and halt.
// Optional feature: define FETCH_TIMEOUT_EN to add an ack-wait timeout that
// raises a sticky fetch_err and halts; without it fetch_err is tied low.
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   pc_q / pc_d / pc_en      PC register Q (in), D and enable (out, combinational)
//   imem_req/addr/ack/rdata  instruction memory handshake; addr is always pc_q
//   instr/instr_valid/ready  held instruction to decode
//   redirect_valid/target    branch/jump redirect
//   halt / halted            stop request / halted status
//   fetch_err                sticky timeout error
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int unsigned PC_STEP        = DEFAULT_PC_STEP,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_d,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        halted,
  output logic        fetch_err
);

  state_e      state_q, state_d;
  logic        halt_pend_q, halt_pend_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic        halted_q, halted_d;
  logic        pc_en_s;
  logic [31:0] pc_d_s;
  logic        capture_s;
  logic        halt_now_s;
  logic        timeout_s;

  // A halt seen while a transaction is outstanding is remembered until the ack.
  assign halt_now_s = halt | halt_pend_q;

  // Next-state, PC update and capture strobe.
  always_comb begin
    state_d     = state_q;
    halt_pend_d = 1'b0;
    pc_en_s     = 1'b0;
    pc_d_s      = 32'h0000_0000;
    capture_s   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        pc_en_s = 1'b1;
        pc_d_s  = RESET_PC;
        if (halt) state_d = ST_HALT;
        else      state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_en_s = 1'b1;
          pc_d_s  = word_align(redirect_target);
          if (halt)          state_d = ST_HALT;
          else if (imem_ack) state_d = ST_FETCH;
          else               state_d = ST_DRAIN;
        end else if (halt) begin
          state_d = ST_HALT;
        end else if (imem_ack) begin
          capture_s = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_en_s = 1'b1;
          pc_d_s  = word_align(redirect_target);
          // An ack in the redirect cycle retires the request: nothing left to drain.
          if (imem_ack) begin
            if (halt_now_s) state_d = ST_HALT;
            else            state_d = ST_FETCH;
          end else begin
            state_d     = ST_DRAIN;
            halt_pend_d = halt_now_s;
          end
        end else if (imem_ack) begin
          if (halt_now_s) begin
            state_d = ST_HALT;
          end else begin
            capture_s = 1'b1;
            state_d   = ST_HOLD;
          end
        end else if (timeout_s) begin
          state_d = ST_HALT;
        end else begin
          halt_pend_d = halt_now_s;
        end
      end
      ST_DRAIN: begin
        if (imem_ack) begin
          if (halt_now_s) state_d = ST_HALT;
          else            state_d = ST_FETCH;
        end else if (timeout_s) begin
          state_d = ST_HALT;
        end else begin
          halt_pend_d = halt_now_s;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          // Redirect beats accept: the held word is dropped, PC is not stepped.
          pc_en_s = 1'b1;
          pc_d_s  = word_align(redirect_target);
          if (halt) state_d = ST_HALT;
          else      state_d = ST_FETCH;
        end else if (instr_ready) begin
          pc_en_s = 1'b1;
          pc_d_s  = pc_q + 32'(PC_STEP);
          if (halt) state_d = ST_HALT;
          else      state_d = ST_FETCH;
        end else if (halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Registered outputs are decoded from the upcoming state.
  always_comb begin
    imem_req_d    = (state_d == ST_FETCH) || (state_d == ST_WAIT);
    instr_valid_d = (state_d == ST_HOLD);
    halted_d      = (state_d == ST_HALT);
  end

  // State and registered-output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      halt_pend_q   <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      halt_pend_q   <= halt_pend_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       fetch_err_q, fetch_err_d;

  // Count no-ack cycles of the current WAIT/DRAIN stay; any entry restarts at 0.
  // Leaving WAIT/DRAIN for HALT without an ack can only be a timeout.
  always_comb begin
    cnt_d       = 8'd0;
    fetch_err_d = fetch_err_q;
    if (((state_d == ST_WAIT) || (state_d == ST_DRAIN)) && (state_d == state_q)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
    if (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && !imem_ack && (state_d == ST_HALT)) begin
      fetch_err_d = 1'b1;
    end else begin
      fetch_err_d = fetch_err_q;
    end
  end

  // Timeout counter and sticky error flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 8'd0;
      fetch_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign timeout_s = (cnt_q == TIMEOUT_LAST);
  assign fetch_err = fetch_err_q;
`else
  assign timeout_s = 1'b0;
  assign fetch_err = 1'b0;
  // TIMEOUT_CYCLES only matters in the timeout build.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  fetch_ctrl_flipflops_32 u_instr_reg (
    .clk (clk),
    .rst (rst),
    .en  (capture_s),
    .d   (imem_rdata),
    .q   (instr)
  );

  assign pc_d        = rst ? 32'h0000_0000 : pc_d_s;
  assign pc_en       = ~rst & pc_en_s;
  assign imem_addr   = pc_q;
  assign imem_req    = imem_req_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Bench for fetch_ctrl: models the external PC register and an instruction
// memory whose word at address A is ~A, runs a directed sequence with literal
// expectations and then randomized stimulus checked every cycle against a
// flag-based transaction model.
module tb_fetch_ctrl;

  localparam logic [31:0] EXP_RESET_PC = 32'h0000_0000;
  localparam int          EXP_TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_reg;
  logic [31:0] pc_d;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        halted;
  logic        fetch_err;

  int n_checks = 0;
  int n_pass   = 0;

  // memory model state
  logic        mem_busy;
  int          mem_wait;
  logic [31:0] mem_addr;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .pc_q            (pc_reg),
    .pc_d            (pc_d),
    .pc_en           (pc_en),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .halted          (halted),
    .fetch_err       (fetch_err)
  );

  // The PC register the block sits in front of.
  initial pc_reg = 32'h1234_5678;
  always @(posedge clk) if (pc_en) pc_reg <= pc_d;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", nm, got, exp, $time);
  endtask

  // One cycle of stimulus; lat is the ack latency of a request starting now.
  task automatic step(input logic r, input logic rv, input logic [31:0] rt,
                      input logic h, input logic rd, input int lat);
    @(posedge clk);
    #1;
    if (imem_ack) mem_busy = 1'b0;
    else if (mem_busy && mem_wait > 0) mem_wait--;
    rst             = r;
    redirect_valid  = rv;
    redirect_target = rt;
    halt            = h;
    instr_ready     = rd;
    if (r) begin
      mem_busy = 1'b0;
    end else if (!mem_busy && imem_req) begin
      mem_busy = 1'b1;
      mem_wait = lat;
      mem_addr = imem_addr;
    end
    imem_ack   = !r && mem_busy && (mem_wait == 0);
    imem_rdata = imem_ack ? ~mem_addr : $urandom();
    #1;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic        m_known = 1'b0;
  logic        m_boot, m_req, m_fresh, m_drain, m_hold, m_halted, m_pend, m_err;
  logic        m_pc_known = 1'b0;
  int          m_cnt;
  logic [31:0] m_pc, m_instr;

  always @(negedge clk) begin : model
    logic        en, ex_en, cap, hp;
    logic [31:0] nd, tgt;
    logic        n_boot, n_req, n_fresh, n_drain, n_hold, n_halted, n_pend, n_err;
    int          n_cnt;
    en = 1'b0; nd = 32'h0; cap = 1'b0;
    n_boot = 1'b0; n_req = 1'b0; n_fresh = 1'b0; n_drain = 1'b0;
    n_hold = 1'b0; n_halted = 1'b0; n_pend = 1'b0; n_err = m_err; n_cnt = 0;
    hp  = halt || m_pend;
    tgt = redirect_target & 32'hFFFF_FFFC;
    if (m_boot) begin
      en = 1'b1; nd = EXP_RESET_PC;
      if (halt) n_halted = 1'b1; else begin n_req = 1'b1; n_fresh = 1'b1; end
    end else if (m_halted) begin
      n_halted = 1'b1;
    end else if (m_req && m_fresh) begin
      if (redirect_valid) begin
        en = 1'b1; nd = tgt;
        if (halt) n_halted = 1'b1;
        else if (imem_ack) begin n_req = 1'b1; n_fresh = 1'b1; end
        else n_drain = 1'b1;
      end else if (halt) n_halted = 1'b1;
      else if (imem_ack) begin n_hold = 1'b1; cap = 1'b1; end
      else n_req = 1'b1;
    end else if (m_req || m_drain) begin
      if (m_req && redirect_valid) begin
        en = 1'b1; nd = tgt;
        if (imem_ack) begin
          if (hp) n_halted = 1'b1; else begin n_req = 1'b1; n_fresh = 1'b1; end
        end else begin
          n_drain = 1'b1; n_pend = hp;
        end
      end else if (imem_ack) begin
        if (hp) n_halted = 1'b1;
        else if (m_drain) begin n_req = 1'b1; n_fresh = 1'b1; end
        else begin n_hold = 1'b1; cap = 1'b1; end
      end else begin
        n_req = m_req; n_drain = m_drain; n_pend = hp; n_cnt = m_cnt + 1;
`ifdef FETCH_TIMEOUT_EN
        if (n_cnt == EXP_TIMEOUT) begin
          n_req = 1'b0; n_drain = 1'b0; n_pend = 1'b0; n_halted = 1'b1; n_err = 1'b1;
        end
`endif
      end
    end else if (m_hold) begin
      if (redirect_valid || instr_ready) begin
        en = 1'b1;
        nd = redirect_valid ? tgt : m_pc + 32'd4;
        if (halt) n_halted = 1'b1; else begin n_req = 1'b1; n_fresh = 1'b1; end
      end else if (halt) n_halted = 1'b1;
      else n_hold = 1'b1;
    end

    if (m_known) begin
      ex_en = rst ? 1'b0 : en;
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_hold});
      chk("halted", {31'b0, halted}, {31'b0, m_halted});
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
      chk("instr_stable", instr, m_instr);
      chk("pc_en", {31'b0, pc_en}, {31'b0, ex_en});
      if (ex_en) chk("pc_d", pc_d, nd);
      if (m_hold) chk("instr_word", instr, ~m_pc);
      if (m_pc_known) chk("imem_addr", imem_addr, m_pc);
    end

    if (rst) begin
      m_known = 1'b1; m_boot = 1'b1; m_req = 1'b0; m_fresh = 1'b0; m_drain = 1'b0;
      m_hold = 1'b0; m_halted = 1'b0; m_pend = 1'b0; m_err = 1'b0; m_cnt = 0;
      m_instr = 32'h0;
    end else if (m_known) begin
      m_boot = n_boot; m_req = n_req; m_fresh = n_fresh; m_drain = n_drain;
      m_hold = n_hold; m_halted = n_halted; m_pend = n_pend; m_err = n_err; m_cnt = n_cnt;
      if (cap) m_instr = imem_rdata;
      if (en) begin m_pc = nd; m_pc_known = 1'b1; end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0]  exp_valid;
    logic [31:0] exp_addr [3];
    int          hrun;
    logic        rv, h, rd;
    logic [31:0] rt;
    exp_valid = 6'b101010;
    exp_addr  = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0; halt = 1'b0;
    instr_ready = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    mem_busy = 1'b0; mem_wait = 0; mem_addr = 32'h0;

    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    // BOOT: reset outputs and RESET_PC load
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
    chk("boot_pc_en", {31'b0, pc_en}, 32'h1);
    chk("boot_pc_d", pc_d, 32'h0000_0000);
    chk("rst_instr", instr, 32'h0000_0000);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    // zero-wait fetches at 0x0, 0x4, 0x8, one instruction every second cycle
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
      chk("seq_valid", {31'b0, instr_valid}, {31'b0, exp_valid[i]});
      if (!exp_valid[i]) chk("seq_addr", imem_addr, exp_addr[i/2]);
    end
    // ack delayed 3 cycles at 0xC
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3);
      chk("wait_req", {31'b0, imem_req}, 32'h1);
      chk("wait_addr", imem_addr, 32'h0000_000C);
      chk("wait_pc_en", {31'b0, pc_en}, 32'h0);
    end
    // HOLD of 0xC: redirect to 0x20 together with ready
    step(1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b1, 0);
    chk("late_instr", instr, 32'hFFFF_FFF3);
    chk("redir_ready_pc_d", pc_d, 32'h0000_0020);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
    chk("redir_addr", imem_addr, 32'h0000_0020);
    // HOLD at 0x20: redirect + ready wins over +4
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
    chk("redir_win_pc_d", pc_d, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
    chk("wrap_pc_d", pc_d, 32'h0000_0000);
    // fetch at 0 wrapped, latency 2, redirect to 0x103 while waiting
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    step(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b1, 0);
    chk("drain_pc_d", pc_d, 32'h0000_0100);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
    chk("drain_req", {31'b0, imem_req}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
    chk("post_drain_addr", imem_addr, 32'h0000_0100);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3);
    chk("post_drain_instr", instr, 32'hFFFF_FEFF);
    // fetch at 0x104 latency 3; halt pulsed in WAIT
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3);
    chk("halt_deferred", {31'b0, halted}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3);
    chk("halt_wait_req", {31'b0, imem_req}, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
    chk("halted_set", {31'b0, halted}, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
    chk("halted_no_req", {31'b0, imem_req}, 32'h0);
    // reset restarts from RESET_PC
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
    chk("restart_pc_d", pc_d, 32'h0000_0000);
    chk("restart_halted", {31'b0, halted}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
    chk("restart_addr", imem_addr, 32'h0000_0000);

    // randomized phase
    hrun = 0;
    for (int k = 0; k < 4000; k++) begin
      hrun = halted ? hrun + 1 : 0;
      rv = ($urandom_range(7) == 0);
      case ($urandom_range(3))
        0:       rt = 32'hFFFF_FFFC;
        1:       rt = 32'hFFFF_FFFF;
        default: rt = $urandom();
      endcase
      h  = ($urandom_range(59) == 0);
      rd = ($urandom_range(3) != 0);
      if (hrun > 4 || $urandom_range(399) == 0)
        step(1'b1, rv, rt, h, rd, 0);
      else
        step(1'b0, rv, rt, h, rd, ($urandom_range(1) == 0) ? 0 : $urandom_range(3));
    end

    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
